fetch_unit: RTL and testbench

- Instruction-fetch stage of the ReduxV core; sits directly upstream of memoria_instrucoes.
- Owns the program counter and drives the ROM address (position); the ROM returns the instruction combinationally in the same cycle (instruction).
- Buffers fetched words in a 2-entry prefetch FIFO and hands them to the decoder over a valid/ready handshake.
- Supports redirect (jump/branch target from execute) and halt.

---
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and buffers fetched
// words in a 2-entry prefetch FIFO toward the decoder over a valid/ready handshake.
//
// state | meaning
// RUN   | fetching; FIFO fills when not full or when the head is consumed
// HALT  | fetch stopped, FIFO empty, PC frozen; left only through rst
module fetch_unit #(
    parameter int              ADDR_W   = 8,
    parameter int              DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] position,
    input  logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt,
    output logic              halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [1:0]        count, count_nxt;
    logic [ADDR_W-1:0] pc0, pc1, pc0_nxt, pc1_nxt;
    logic [DATA_W-1:0] d0, d1, d0_nxt, d1_nxt;
    logic [1:0]        occ;
    logic              deq;
    logic              fetch;

    assign deq         = (state == RUN) && (count != 2'd0) && instr_ready;
    assign position    = pc;
    assign instr_valid = (count != 2'd0);
    assign instr_out   = d0;
    assign instr_pc    = pc0;
    assign halted      = (state == HALT);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        count_nxt = count;
        pc0_nxt   = pc0;
        pc1_nxt   = pc1;
        d0_nxt    = d0;
        d1_nxt    = d1;
        fetch     = 1'b0;
        occ       = count;
        case (state)
            RUN: begin
                if (halt) begin
                    state_nxt = HALT;
                    count_nxt = 2'd0;
                end else if (redirect) begin
                    count_nxt = 2'd0;
                    pc_nxt    = redirect_target;
                end else begin
                    fetch = (count < 2'd2) || deq;
                    // Shift the FIFO on dequeue so the head always lives in entry 0.
                    if (deq) begin
                        pc0_nxt = pc1;
                        d0_nxt  = d1;
                    end
                    occ = count - 2'(deq);
                    if (fetch) begin
                        pc_nxt = pc + ADDR_W'(1);
                        if (occ == 2'd0) begin
                            pc0_nxt = pc;
                            d0_nxt  = instruction;
                        end else begin
                            pc1_nxt = pc;
                            d1_nxt  = instruction;
                        end
                    end
                    count_nxt = occ + 2'(fetch);
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
            count <= 2'd0;
            pc0   <= '0;
            pc1   <= '0;
            d0    <= '0;
            d1    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            count <= count_nxt;
            pc0   <= pc0_nxt;
            pc1   <= pc1_nxt;
            d0    <= d0_nxt;
            d1    <= d1_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences and
// random traffic checked against a queue-based reference model.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] position;
    logic [7:0] instruction;
    logic [7:0] instr_out;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic       redirect = 1'b0;
    logic [7:0] redirect_target = 8'h00;
    logic       halt = 1'b0;
    logic       halted;

    logic [7:0] rom [256];
    assign instruction = rom[position];

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .position(position), .instruction(instruction),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_target(redirect_target),
        .halt(halt), .halted(halted)
    );

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] ins;
    } ent_t;

    ent_t       q[$];
    logic [7:0] m_pc;
    logic       m_halted;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc     = 8'h00;
        m_halted = 1'b0;
    endtask

    task automatic model_edge();
        bit deq;
        if (!m_halted) begin
            deq = (q.size() != 0) && instr_ready;
            if (halt) begin
                m_halted = 1'b1;
                q.delete();
            end else if (redirect) begin
                q.delete();
                m_pc = redirect_target;
            end else begin
                if (deq) void'(q.pop_front());
                if (q.size() < 2) begin
                    q.push_back({m_pc, rom[m_pc]});
                    m_pc = m_pc + 8'd1;
                end
            end
        end
    endtask

    task automatic compare_model();
        chk("model_valid", int'(instr_valid), int'(q.size() != 0));
        chk("model_position", int'(position), int'(m_pc));
        chk("model_halted", int'(halted), int'(m_halted));
        if (q.size() != 0) begin
            chk("model_pc", int'(instr_pc), int'(q[0].pc));
            chk("model_out", int'(instr_out), int'(q[0].ins));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic set_in(input bit rdy, input bit rd, input logic [7:0] tgt, input bit h);
        instr_ready     = rdy;
        redirect        = rd;
        redirect_target = tgt;
        halt            = h;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", int'(instr_valid), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_position", int'(position), 0);
        chk("rst_out", int'(instr_out), 0);
        chk("rst_pc", int'(instr_pc), 0);
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         rdy;
        bit         rd;
        logic [7:0] tgt;
        bit         h;
        bit         e_valid;
        logic [7:0] e_pc;
        logic [7:0] e_pos;
        bit         e_halted;
    } vec_t;

    vec_t vecs[9];
    int   n;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);

        //            rdy rd  tgt    h  valid pc     pos    halted
        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h03, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 8'h04, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 8'h20, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h20, 8'h21, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 8'h21, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 8'h21, 1'b1};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", int'(instr_valid), 0);
        chk("init_position", int'(position), 0);
        chk("init_halted", int'(halted), 0);
        chk("init_out", int'(instr_out), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table: backpressure, redirect, halt with redirect.
        for (int i = 0; i < 9; i++) begin
            set_in(vecs[i].rdy, vecs[i].rd, vecs[i].tgt, vecs[i].h);
            step();
            chk("vec_valid", int'(instr_valid), int'(vecs[i].e_valid));
            chk("vec_position", int'(position), int'(vecs[i].e_pos));
            chk("vec_halted", int'(halted), int'(vecs[i].e_halted));
            if (vecs[i].e_valid) begin
                chk("vec_pc", int'(instr_pc), int'(vecs[i].e_pc));
                chk("vec_out", int'(instr_out), int'(rom[vecs[i].e_pc]));
            end
        end

        // Streaming: 35 consecutive words, one per cycle.
        do_reset();
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 35; i++) begin
            step();
            chk("stream_valid", int'(instr_valid), 1);
            chk("stream_pc", int'(instr_pc), i);
            chk("stream_out", int'(instr_out), int'(rom[i]));
        end

        // Redirect while head is pc 0x05; pc 0x06 must never be delivered.
        do_reset();
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        n = 0;
        while (!(instr_valid && instr_pc == 8'h05) && n < 20) begin
            step();
            n++;
        end
        chk("redir_reach_head5", int'(instr_pc), 5);
        set_in(1'b1, 1'b1, 8'h20, 1'b0);
        step();
        chk("redir_gap_valid", int'(instr_valid), 0);
        chk("redir_gap_position", int'(position), 8'h20);
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        step();
        chk("redir_target_pc", int'(instr_pc), 8'h20);
        chk("redir_target_out", int'(instr_out), int'(rom[8'h20]));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("redir_no_stale", int'(instr_pc == 8'h06), 0);
        end

        // Wrap-around of the PC.
        set_in(1'b1, 1'b1, 8'hFE, 1'b0);
        step();
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wrap_pc", int'(instr_pc), int'(8'(8'hFE + i)));
        end

        // Halt together with redirect at position 0x08.
        do_reset();
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        n = 0;
        while (position != 8'h08 && n < 20) begin
            step();
            n++;
        end
        chk("halt_reach_pos8", int'(position), 8);
        set_in(1'b1, 1'b1, 8'h10, 1'b1);
        step();
        chk("halt_halted", int'(halted), 1);
        chk("halt_valid", int'(instr_valid), 0);
        chk("halt_position", int'(position), 8);
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            set_in(1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
            step();
            chk("halt_hold_position", int'(position), 8);
            chk("halt_hold_valid", int'(instr_valid), 0);
        end

        // Async reset while the FIFO is full, then first fetch is ROM[0].
        do_reset();
        repeat (3) step();
        chk("full_before_rst", int'(q.size()), 2);
        do_reset();
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        step();
        chk("post_rst_pc", int'(instr_pc), 0);
        chk("post_rst_out", int'(instr_out), int'(rom[0]));

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                   8'($urandom), $urandom_range(0, 299) == 0);
            step();
            if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0)
                do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
